// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage.
// Splits instruction words into funct/immA/immB over a valid/ready handshake,
// assembles the two-word long form, flags illegal funct codes and counts
// delivered results. Optional feature macro: IDEC_SIGNEXT_EN selects
// sign-extension of short-form immediates (zero-extension when undefined).
module instr_decode_stage #(
    parameter int IMM_W     = 14,
    parameter int FUNCT_W   = 3,
    parameter int INSTR_W   = 32,
    parameter int OUT_W     = 16,
    parameter int FUNCT_MAX = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FUNCT_W-1:0] out_funct,
    output logic [OUT_W-1:0]   out_immA,
    output logic [OUT_W-1:0]   out_immB,
    output logic               out_long,
    output logic               out_illegal,
    output logic [15:0]        decode_count
);

    typedef enum logic {FIRST, EXT} state_t;

    localparam logic [FUNCT_W-1:0] FUNCT_MAX_L = FUNCT_MAX[FUNCT_W-1:0];

    state_t               state_q, state_d;
    logic                 valid_q, valid_d;
    logic [FUNCT_W-1:0]   funct_q, funct_d;
    logic [OUT_W-1:0]     immA_q, immA_d;
    logic [OUT_W-1:0]     immB_q, immB_d;
    logic                 long_q, long_d;
    logic                 illegal_q, illegal_d;
    logic [15:0]          count_q, count_d;
    logic [FUNCT_W-1:0]   holdFunct_q, holdFunct_d;
    logic [OUT_W-1:0]     holdImmA_q, holdImmA_d;

    logic                 accept;
    logic                 deliver;
    logic                 wordLong;
    logic [FUNCT_W-1:0]   wordFunct;
    logic [IMM_W-1:0]     wordImmA;
    logic [IMM_W-1:0]     wordImmB;

    // Widen a short-form immediate field to the output width.
    function automatic logic [OUT_W-1:0] extendImm(input logic [IMM_W-1:0] f);
`ifdef IDEC_SIGNEXT_EN
        return OUT_W'($signed(f));
`else
        return OUT_W'(f);
`endif
    endfunction

    assign wordLong  = in_instr[INSTR_W-1];
    assign wordFunct = in_instr[INSTR_W-2 -: FUNCT_W];
    assign wordImmA  = in_instr[2*IMM_W-1:IMM_W];
    assign wordImmB  = in_instr[IMM_W-1:0];

    // The output register can take a new word whenever it is empty or being emptied.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = valid_q && out_ready;

    assign out_valid    = valid_q;
    assign out_funct    = funct_q;
    assign out_immA     = immA_q;
    assign out_immB     = immB_q;
    assign out_long     = long_q;
    assign out_illegal  = illegal_q;
    assign decode_count = count_q;

    // Next-state logic: flush wins over accept; a delivered result empties the register.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q && !out_ready;
        funct_d     = funct_q;
        immA_d      = immA_q;
        immB_d      = immB_q;
        long_d      = long_q;
        illegal_d   = illegal_q;
        count_d     = deliver ? count_q + 16'd1 : count_q;
        holdFunct_d = holdFunct_q;
        holdImmA_d  = holdImmA_q;

        if (flush) begin
            valid_d = 1'b0;
            state_d = FIRST;
            count_d = count_q;
        end else if (accept) begin
            unique case (state_q)
                FIRST: begin
                    if (wordLong) begin
                        holdFunct_d = wordFunct;
                        holdImmA_d  = extendImm(wordImmA);
                        state_d     = EXT;
                    end else begin
                        valid_d   = 1'b1;
                        funct_d   = wordFunct;
                        immA_d    = extendImm(wordImmA);
                        immB_d    = extendImm(wordImmB);
                        long_d    = 1'b0;
                        illegal_d = wordFunct > FUNCT_MAX_L;
                    end
                end
                EXT: begin
                    valid_d   = 1'b1;
                    funct_d   = holdFunct_q;
                    immA_d    = holdImmA_q;
                    immB_d    = in_instr[OUT_W-1:0];
                    long_d    = 1'b1;
                    illegal_d = holdFunct_q > FUNCT_MAX_L;
                    state_d   = FIRST;
                end
                default: state_d = FIRST;
            endcase
        end
    end

    // State, output and holding registers; reset also discards a held first word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FIRST;
            valid_q     <= 1'b0;
            funct_q     <= '0;
            immA_q      <= '0;
            immB_q      <= '0;
            long_q      <= 1'b0;
            illegal_q   <= 1'b0;
            count_q     <= '0;
            holdFunct_q <= '0;
            holdImmA_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            funct_q     <= funct_d;
            immA_q      <= immA_d;
            immB_q      <= immB_d;
            long_q      <= long_d;
            illegal_q   <= illegal_d;
            count_q     <= count_d;
            holdFunct_q <= holdFunct_d;
            holdImmA_q  <= holdImmA_d;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed cases plus random traffic
// checked through a scoreboard fed by a word-level reference model.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_funct;
    logic [15:0] out_immA;
    logic [15:0] out_immB;
    logic        out_long;
    logic        out_illegal;
    logic [15:0] decode_count;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [2:0]  funct;
        logic [15:0] immA;
        logic [15:0] immB;
        logic        isLong;
        logic        illegal;
    } exp_t;

    exp_t expQ[$];

    // Reference model state: a pending long-form first word.
    bit          pending = 0;
    logic [2:0]  pendFunct;
    logic [15:0] pendImmA;
    int          expCount = 0;

    instr_decode_stage dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_funct    (out_funct),
        .out_immA     (out_immA),
        .out_immB     (out_immB),
        .out_long     (out_long),
        .out_illegal  (out_illegal),
        .decode_count (decode_count)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Widen a 14-bit immediate value to 16 bits the way the configured build should.
    function automatic logic [15:0] widenImm(input int v);
`ifdef IDEC_SIGNEXT_EN
        if (v >= 8192) return 16'(v + 49152);
`endif
        return 16'(v);
    endfunction

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Present one word and hold it until the stage takes it, with a bounded wait.
    task automatic applyStimulus(input logic [31:0] w);
        bit taken = 0;
        in_valid = 1'b1;
        in_instr = w;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1;
                break;
            end
        end
        if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Reference model: watches accepted words and queues the results they should produce.
    always @(negedge clk) begin
        if (reset) begin
            pending = 0;
            expQ.delete();
        end else if (flush) begin
            pending = 0;
            expQ.delete();
        end else if (in_valid && in_ready) begin
            int fn;
            int a;
            int b;
            exp_t e;
            fn = int'((in_instr >> 28) & 32'h7);
            a  = int'((in_instr >> 14) & 32'h3FFF);
            b  = int'(in_instr & 32'h3FFF);
            if (pending) begin
                e.funct   = pendFunct;
                e.immA    = pendImmA;
                e.immB    = in_instr[15:0];
                e.isLong  = 1'b1;
                e.illegal = (pendFunct > 3'd5);
                expQ.push_back(e);
                pending = 0;
            end else if (in_instr[31]) begin
                pending   = 1;
                pendFunct = 3'(fn);
                pendImmA  = widenImm(a);
            end else begin
                e.funct   = 3'(fn);
                e.immA    = widenImm(a);
                e.immB    = widenImm(b);
                e.isLong  = 1'b0;
                e.illegal = (fn > 5);
                expQ.push_back(e);
            end
        end
    end

    // Monitor: on every delivery pop the oldest expected result and compare.
    always @(negedge clk) begin
        if (reset) begin
            expCount = 0;
        end else if (out_valid && out_ready && !flush) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sb_funct",   32'(out_funct),    32'(e.funct));
                checkOutput("sb_immA",    32'(out_immA),     32'(e.immA));
                checkOutput("sb_immB",    32'(out_immB),     32'(e.immB));
                checkOutput("sb_long",    32'(out_long),     32'(e.isLong));
                checkOutput("sb_illegal", 32'(out_illegal),  32'(e.illegal));
            end
            checkOutput("sb_count", 32'(decode_count), 32'(expCount % 65536));
            expCount++;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        logic [15:0] immBShort;
`ifdef IDEC_SIGNEXT_EN
        immBShort = 16'hFFFF;
`else
        immBShort = 16'h3FFF;
`endif
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid",   32'(out_valid),    32'd0);
        checkOutput("rst_ready",   32'(in_ready),     32'd1);
        checkOutput("rst_funct",   32'(out_funct),    32'd0);
        checkOutput("rst_immA",    32'(out_immA),     32'd0);
        checkOutput("rst_immB",    32'(out_immB),     32'd0);
        checkOutput("rst_long",    32'(out_long),     32'd0);
        checkOutput("rst_illegal", 32'(out_illegal),  32'd0);
        checkOutput("rst_count",   32'(decode_count), 32'd0);
        reset = 1'b0;

        // Short word held under backpressure, outputs frozen, second word refused.
        applyStimulus(32'h20017FFF);
        checkOutput("short_valid", 32'(out_valid), 32'd1);
        checkOutput("short_funct", 32'(out_funct), 32'd2);
        checkOutput("short_immA",  32'(out_immA),  32'h0005);
        checkOutput("short_immB",  32'(out_immB),  32'(immBShort));
        checkOutput("short_long",  32'(out_long),  32'd0);
        in_valid = 1'b1;
        in_instr = 32'h70000000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_in_ready", 32'(in_ready),  32'd0);
        checkOutput("bp_frozen_f", 32'(out_funct), 32'd2);
        checkOutput("bp_frozen_b", 32'(out_immB),  32'(immBShort));

        // Deliver and reload in the same cycle.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("reload_valid",   32'(out_valid),   32'd1);
        checkOutput("reload_funct",   32'(out_funct),   32'd7);
        checkOutput("reload_illegal", 32'(out_illegal), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("count_after_2", 32'(decode_count), 32'd2);

        // Long form on consecutive cycles.
        in_valid = 1'b1;
        in_instr = 32'h90000000;
        @(posedge clk);
        #1;
        checkOutput("long_no_first", 32'(out_valid), 32'd0);
        in_instr = 32'h0000ABCD;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("long_valid", 32'(out_valid), 32'd1);
        checkOutput("long_funct", 32'(out_funct), 32'd1);
        checkOutput("long_immA",  32'(out_immA),  32'd0);
        checkOutput("long_immB",  32'(out_immB),  32'hABCD);
        checkOutput("long_flag",  32'(out_long),  32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Flush mid-long-form, with a word presented in the flush cycle.
        out_ready = 1'b0;
        applyStimulus(32'h90000000);
        in_valid = 1'b1;
        in_instr = 32'h0000ABCD;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_drop", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        applyStimulus(32'h00004003);
        checkOutput("flush_next_immA", 32'(out_immA), 32'd1);
        checkOutput("flush_next_immB", 32'(out_immB), 32'd3);
        checkOutput("flush_next_long", 32'(out_long), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Flush drops a held short result without counting it.
        out_ready = 1'b0;
        applyStimulus(32'h00001001);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_held", 32'(out_valid), 32'd0);
        checkOutput("flush_count", 32'(decode_count), 32'd4);
        out_ready = 1'b1;

        // Reset mid-long-form.
        applyStimulus(32'h90000000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_count", 32'(decode_count), 32'd0);
        applyStimulus(32'h00004003);
        checkOutput("reset_next_immA", 32'(out_immA), 32'd1);
        checkOutput("reset_next_immB", 32'(out_immB), 32'd3);
        checkOutput("reset_next_long", 32'(out_long), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_instr  = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("random_drained", 32'(expQ.size()), 32'd0);

        // Long stream of short words to wrap the delivery counter.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            in_instr = $urandom & 32'h7FFFFFFF;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("wrap_count",   32'(decode_count), 32'd1);
        checkOutput("wrap_drained", 32'(expQ.size()),  32'd0);
        checkOutput("wrap_total",   32'(expCount),     32'd65537);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
